ifid_skid_stage: RTL

- Parametrised successor to the IF/ID pipeline register: carries instruction plus PC from fetch to decode.
- Uses a valid/ready handshake instead of a bare stall line.
- A 2-entry skid buffer absorbs one extra fetch when decode back-pressures, so ready_o is fully registered and the fetch-side ready path is not combinational.
- Synchronous flush inserts a bubble instruction for branch/jump squash.

---
 rtl/ifid_pkg.sv | 16 +
 rtl/ifid_slot.sv | 44 ++++
 rtl/ifid_skid_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ifid_pkg.sv
// Shared types and defaults for the IF/ID skid stage.
// Holds the stage occupancy enum, the bubble encoding and default widths.
package ifid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } ifid_state_e;

    localparam logic [31:0] IFID_BUBBLE_INST = 32'hFC000000;
    localparam int          IFID_INST_W      = 32;
    localparam int          IFID_PC_W        = 32;
    localparam int          IFID_CNT_W       = 16;

endpackage

// File: rtl/ifid_slot.sv
// One valid+inst+pc holding register with load enable and clear-to-bubble.
// Clear wins over load; clear keeps the PC so decode still sees the last address.
module ifid_slot
    import ifid_pkg::*;
#(
    parameter int                 INST_W = IFID_INST_W,
    parameter int                 PC_W   = IFID_PC_W,
    parameter logic [INST_W-1:0]  BUBBLE = INST_W'(IFID_BUBBLE_INST)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [INST_W-1:0] i_inst,
    input  logic [PC_W-1:0]   i_pc,
    output logic              o_vld,
    output logic [INST_W-1:0] o_inst,
    output logic [PC_W-1:0]   o_pc
);

    logic              r_vld;
    logic [INST_W-1:0] r_inst;
    logic [PC_W-1:0]   r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld  <= 1'b0;
            r_inst <= BUBBLE;
            r_pc   <= '0;
        end else if (i_clear) begin
            r_vld  <= 1'b0;
            r_inst <= BUBBLE;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_inst <= i_inst;
            r_pc   <= i_pc;
        end
    end

    assign o_vld  = r_vld;
    assign o_inst = r_inst;
    assign o_pc   = r_pc;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage with a 2-entry skid buffer and valid/ready on both sides.
// Latency 1 cycle, full throughput; ready_o comes straight from the skid valid flop.
// Optional perf counters behind `IFID_SKID_PERF_CNT_EN (stall and useful-flush cycles).
module ifid_skid_stage
    import ifid_pkg::*;
#(
    parameter int                INST_W      = IFID_INST_W,
    parameter int                PC_W        = IFID_PC_W,
    parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(IFID_BUBBLE_INST),
    parameter int                CNT_W       = IFID_CNT_W
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
`ifdef IFID_SKID_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
`endif
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o
);

    ifid_state_e       r_state;
    ifid_state_e       w_state_nxt;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic              w_skid_clear;

    logic              w_main_vld;
    logic              w_skid_vld;
    logic [INST_W-1:0] w_skid_inst;
    logic [PC_W-1:0]   w_skid_pc;
    logic [INST_W-1:0] w_main_inst_d;
    logic [PC_W-1:0]   w_main_pc_d;

    assign w_in_fire  = valid_i & ready_o;
    assign w_out_fire = valid_o & ready_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush_i) begin
            w_state_nxt  = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_main_inst_d = w_main_from_skid ? w_skid_inst : inst_i;
    assign w_main_pc_d   = w_main_from_skid ? w_skid_pc   : pc_i;

    ifid_slot #(
        .INST_W (INST_W),
        .PC_W   (PC_W),
        .BUBBLE (BUBBLE_INST)
    ) u_main (
        .i_clk   (clk_i),
        .i_rst_n (start_i),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_inst  (w_main_inst_d),
        .i_pc    (w_main_pc_d),
        .o_vld   (w_main_vld),
        .o_inst  (inst_o),
        .o_pc    (pc_o)
    );

    ifid_slot #(
        .INST_W (INST_W),
        .PC_W   (PC_W),
        .BUBBLE (BUBBLE_INST)
    ) u_skid (
        .i_clk   (clk_i),
        .i_rst_n (start_i),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_inst  (inst_i),
        .i_pc    (pc_i),
        .o_vld   (w_skid_vld),
        .o_inst  (w_skid_inst),
        .o_pc    (w_skid_pc)
    );

    // Skid occupancy is exactly the FULL state, so ready_o is a pure flop output.
    assign valid_o = w_main_vld;
    assign ready_o = ~w_skid_vld;

`ifdef IFID_SKID_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_flush_hit;

    assign w_flush_hit = flush_i & (valid_o | w_in_fire);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (valid_o && !ready_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_hit && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
